wb_sdrc_arbiter: RTL and testbench

WB_SDRC_ARBITER -- requirements
Module: wb_sdrc_arbiter

---
 rtl/wb_sdrc_arbiter_pkg.sv | 18 +
 rtl/wb_rr_pick.sv | 33 +++
 rtl/wb_sdrc_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_sdrc_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sdrc_arbiter_pkg.sv
// Shared types and constants for the Wishbone-to-SDRAM-controller arbiter.
package wb_sdrc_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant wins, one-hot result.
module wb_rr_pick
  import wb_sdrc_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_M = 4,
  localparam int unsigned LW    = idx_width(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [LW-1:0]    last_grant,
  output logic [NUM_M-1:0] grant_c,
  output logic [LW-1:0]    grant_idx_c
);

  logic          found;
  logic [LW-1:0] idx;

  // Scan offsets 1..NUM_M so last_grant itself is considered last.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      idx = LW'((32'(last_grant) + k) % NUM_M);
      if (!found && req[idx]) begin
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sdrc_arbiter.sv
// Round-robin Wishbone arbiter in front of an SDRAM controller slave, with
// per-grant stall timeout and a dead cycle between consecutive grants.
module wb_sdrc_arbiter
  import wb_sdrc_arbiter_pkg::*;
#(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 26,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  sdr_init_done,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M*AW-1:0]   m_addr_i,
  input  logic [NUM_M*DW-1:0]   m_dat_i,
  input  logic [NUM_M*DW/8-1:0] m_sel_i,
  input  logic [NUM_M*3-1:0]    m_cti_i,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic [DW-1:0]         m_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [AW-1:0]         s_addr_o,
  output logic [DW-1:0]         s_dat_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic [2:0]            s_cti_o,
  input  logic                  s_ack_i,
  input  logic [DW-1:0]         s_dat_i,
  output logic [NUM_M-1:0]      grant_o
);

  localparam int unsigned LW = idx_width(NUM_M);
  localparam int unsigned CW = idx_width(TIMEOUT);
  localparam int unsigned SW = DW / 8;

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [LW-1:0]    gidx_q, gidx_d;
  logic [LW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NUM_M-1:0] pick_grant;
  logic [LW-1:0]    pick_idx;

  logic             in_grant;
  logic             tmo_hit;
  logic             sel_cyc, sel_stb, sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_dat;
  logic [SW-1:0]    sel_sel;
  logic [2:0]       sel_cti;

  wb_rr_pick #(
    .NUM_M (NUM_M)
  ) u_pick (
    .req         (m_cyc_i),
    .last_grant  (last_q),
    .grant_c     (pick_grant),
    .grant_idx_c (pick_idx)
  );

  // Select the granted master's request bundle.
  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_dat  = '0;
    sel_sel  = '0;
    sel_cti  = CTI_CLASSIC;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (gidx_q == LW'(i)) begin
        sel_cyc  = m_cyc_i[i];
        sel_stb  = m_stb_i[i];
        sel_we   = m_we_i[i];
        sel_addr = m_addr_i[i*AW +: AW];
        sel_dat  = m_dat_i[i*DW +: DW];
        sel_sel  = m_sel_i[i*SW +: SW];
        sel_cti  = m_cti_i[i*3 +: 3];
      end
    end
  end

  assign in_grant = (state_q == ST_GRANT);
  assign tmo_hit  = in_grant && sel_stb && (cnt_q == CW'(TIMEOUT - 1));

  // Slave side: straight pass-through of the granted master; strobe dropped on timeout.
  assign s_cyc_o  = in_grant & sel_cyc;
  assign s_stb_o  = in_grant & sel_stb & ~tmo_hit;
  assign s_we_o   = in_grant & sel_we;
  assign s_addr_o = in_grant ? sel_addr : '0;
  assign s_dat_o  = in_grant ? sel_dat  : '0;
  assign s_sel_o  = in_grant ? sel_sel  : '0;
  assign s_cti_o  = in_grant ? sel_cti  : CTI_CLASSIC;

  assign m_ack_o  = (in_grant && !tmo_hit) ? (grant_q & {NUM_M{s_ack_i}}) : '0;
  assign m_err_o  = tmo_hit ? grant_q : '0;
  assign m_dat_o  = s_dat_i;
  assign grant_o  = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (sdr_init_done && (|m_cyc_i)) begin
          state_d = ST_GRANT;
          grant_d = pick_grant;
          gidx_d  = pick_idx;
        end
      end
      ST_GRANT: begin
        if (sel_stb && !s_ack_i && !tmo_hit) begin
          cnt_d = cnt_q + CW'(1);
        end
        // Grant persists through bursts and timeouts until the owner releases cyc.
        if (!sel_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LW'(NUM_M - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Scoreboard bench for wb_sdrc_arbiter: grant order and acked beats are queued
// ahead of stimulus and popped as the arbiter produces them.
module tb_wb_sdrc_arbiter;
  import wb_sdrc_arbiter_pkg::*;

  localparam int NUM_M = 4, DW = 32, AW = 26, TIMEOUT = 64, SW = DW / 8;

  typedef logic [1:0] mid_t;
  typedef struct {
    mid_t          m;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i, sdr_init_done;
  logic [NUM_M-1:0]    m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, grant_o;
  logic [NUM_M*AW-1:0] m_addr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [NUM_M*SW-1:0] m_sel_i;
  logic [NUM_M*3-1:0]  m_cti_i;
  logic [DW-1:0]       m_dat_o, s_dat_o, s_dat_i;
  logic                s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [AW-1:0]       s_addr_o;
  logic [SW-1:0]       s_sel_o;
  logic [2:0]          s_cti_o;

  logic          tcyc [NUM_M];
  logic          tstb [NUM_M];
  logic          twe  [NUM_M];
  logic [AW-1:0] taddr[NUM_M];
  logic [DW-1:0] tdat [NUM_M];
  logic [2:0]    tcti [NUM_M];

  logic          slave_en;
  logic [DW-1:0] mem [0:1023];

  int    checks = 0, failures = 0;
  int    run_id = 0, last_run = -1, gap = 0;
  bit    tight = 0;
  logic [NUM_M-1:0] prev_grant = '0;
  mid_t  gq[$];
  beat_t sq[$];

  always #5 wb_clk_i = ~wb_clk_i;

  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      m_cyc_i[i]            = tcyc[i];
      m_stb_i[i]            = tstb[i];
      m_we_i[i]             = twe[i];
      m_addr_i[i*AW +: AW]  = taddr[i];
      m_dat_i[i*DW +: DW]   = tdat[i];
      m_cti_i[i*3 +: 3]     = tcti[i];
    end
  end
  assign m_sel_i = '1;

  // Zero-wait slave memory; ack can be withheld to provoke timeouts.
  assign s_ack_i = s_cyc_o & s_stb_o & slave_en;
  assign s_dat_i = mem[s_addr_o[11:2]];
  always @(posedge wb_clk_i) if (s_ack_i && s_we_o) mem[s_addr_o[11:2]] <= s_dat_o;

  wb_sdrc_arbiter #(.NUM_M(NUM_M), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .sdr_init_done(sdr_init_done),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_beats(input mid_t m, input bit we, input logic [AW-1:0] addr,
                            input int beats, input logic [DW-1:0] data0);
    for (int b = 0; b < beats; b++) begin
      beat_t it;
      it.m = m; it.we = we; it.addr = addr + AW'(4 * b); it.data = data0 + DW'(b);
      sq.push_back(it);
    end
  endtask

  // Master-side driver; stop_after>0 abandons the burst with cyc still held.
  task automatic wb_burst(input mid_t m, input bit we, input logic [AW-1:0] addr,
                          input int beats, input logic [DW-1:0] data0, input int stop_after);
    int b = 0;
    bit got;
    tcyc[m] = 1'b1; tstb[m] = 1'b1; twe[m] = we; taddr[m] = addr; tdat[m] = data0;
    tcti[m] = (beats == 1) ? CTI_CLASSIC : ((beats == 2) ? CTI_INCR : CTI_INCR);
    while (b < beats) begin
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge wb_clk_i);
        got = m_ack_o[m];
      end
      if (!got) begin
        check("ack_timeout", 64'(got), 64'd1);
        tcyc[m] = 1'b0; tstb[m] = 1'b0;
        return;
      end
      @(posedge wb_clk_i); #1;
      b++;
      if (stop_after != 0 && b == stop_after) begin
        tstb[m] = 1'b0;
        return;
      end
      if (b == beats) begin
        tcyc[m] = 1'b0; tstb[m] = 1'b0; tcti[m] = CTI_CLASSIC;
      end else begin
        taddr[m] = addr + AW'(4 * b);
        tdat[m]  = data0 + DW'(b);
        tcti[m]  = (b == beats - 1) ? CTI_EOB : CTI_INCR;
      end
    end
  endtask

  // Monitor: grant order / dead cycle, then acked beats against the scoreboard.
  always @(negedge wb_clk_i) begin
    if (grant_o == '0) begin
      gap++;
    end else if (grant_o != prev_grant) begin
      if (tight && last_run == run_id) check("dead_cycle", 64'(gap), 64'd1);
      last_run = run_id;
      if (gq.size() == 0) check("grant_extra", 64'(grant_o), 64'd0);
      else check("grant_order", 64'(grant_o), 64'd1 << gq.pop_front());
      gap = 0;
    end
    prev_grant = grant_o;
    if (m_ack_o != '0) begin
      if (sq.size() == 0) begin
        check("ack_extra", 64'(m_ack_o), 64'd0);
      end else begin
        beat_t it;
        it = sq.pop_front();
        check("ack_master", 64'(m_ack_o), 64'd1 << it.m);
        check("ack_addr", 64'(s_addr_o), 64'(it.addr));
        if (!it.we) check("rd_data", 64'(m_dat_o), 64'(it.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int gcyc, errc, acks;
    logic stb_err;
    logic [NUM_M-1:0] err_vec;
    wb_rst_i = 1'b1; sdr_init_done = 1'b0; slave_en = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      tcyc[i] = 1'b0; tstb[i] = 1'b0; twe[i] = 1'b0;
      taddr[i] = '0; tdat[i] = '0; tcti[i] = CTI_CLASSIC;
    end
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_grant", 64'(grant_o), 64'd0);
    check("rst_scyc", 64'(s_cyc_o), 64'd0);
    check("rst_sstb", 64'(s_stb_o), 64'd0);
    check("rst_ack", 64'(m_ack_o), 64'd0);
    check("rst_err", 64'(m_err_o), 64'd0);

    // No grants while SDRAM init is pending, even with every master requesting.
    for (int i = 0; i < NUM_M; i++) tcyc[i] = 1'b1;
    repeat (100) begin
      @(negedge wb_clk_i);
      check("noinit_grant", 64'(grant_o), 64'd0);
      check("noinit_scyc", 64'(s_cyc_o), 64'd0);
    end
    for (int i = 0; i < NUM_M; i++) tcyc[i] = 1'b0;
    @(posedge wb_clk_i); #1 sdr_init_done = 1'b1;
    @(posedge wb_clk_i); #1;

    // Four concurrent single writes, master 0 asks twice.
    run_id++; tight = 1;
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
    push_beats(0, 1, 26'h000, 1, 32'h10);
    push_beats(1, 1, 26'h004, 1, 32'h11);
    push_beats(2, 1, 26'h008, 1, 32'h12);
    push_beats(3, 1, 26'h00C, 1, 32'h13);
    push_beats(0, 1, 26'h010, 1, 32'h14);
    fork
      begin
        wb_burst(0, 1, 26'h000, 1, 32'h10, 0);
        @(posedge wb_clk_i); #1;
        wb_burst(0, 1, 26'h010, 1, 32'h14, 0);
      end
      wb_burst(1, 1, 26'h004, 1, 32'h11, 0);
      wb_burst(2, 1, 26'h008, 1, 32'h12, 0);
      wb_burst(3, 1, 26'h00C, 1, 32'h13, 0);
    join
    repeat (3) @(posedge wb_clk_i); #1;

    // Master 2 burst write then burst read-back.
    run_id++; tight = 0;
    gq.push_back(2); gq.push_back(2);
    push_beats(2, 1, 26'h100, 4, 32'hA0);
    push_beats(2, 0, 26'h100, 4, 32'hA0);
    wb_burst(2, 1, 26'h100, 4, 32'hA0, 0);
    @(posedge wb_clk_i); #1;
    wb_burst(2, 0, 26'h100, 4, 32'hA0, 0);
    repeat (3) @(posedge wb_clk_i); #1;

    // Master 1 read with ack withheld.
    run_id++; slave_en = 1'b0;
    gq.push_back(1);
    gcyc = 0; errc = 0; acks = 0; stb_err = 1'b1; err_vec = '0;
    tcyc[1] = 1'b1; tstb[1] = 1'b1; twe[1] = 1'b0; taddr[1] = 26'h300; tcti[1] = CTI_CLASSIC;
    for (int t = 0; t < 300 && errc == 0; t++) begin
      @(negedge wb_clk_i);
      if (grant_o[1]) gcyc++;
      if (m_ack_o[1]) acks++;
      if (m_err_o != '0) begin
        errc = gcyc; stb_err = s_stb_o; err_vec = m_err_o;
      end
    end
    check("tmo_cycle", 64'(errc), 64'(TIMEOUT));
    check("tmo_err_vec", 64'(err_vec), 64'h2);
    check("tmo_stb_mask", 64'(stb_err), 64'd0);
    check("tmo_no_ack", 64'(acks), 64'd0);
    @(negedge wb_clk_i);
    check("tmo_pulse", 64'(m_err_o), 64'd0);
    check("tmo_grant_kept", 64'(grant_o), 64'h2);
    @(posedge wb_clk_i); #1;
    tcyc[1] = 1'b0; tstb[1] = 1'b0; slave_en = 1'b1;
    repeat (2) @(posedge wb_clk_i); #1;

    // Reset in the middle of a master 3 burst.
    run_id++; tight = 0;
    gq.push_back(3);
    push_beats(3, 1, 26'h200, 2, 32'hB0);
    wb_burst(3, 1, 26'h200, 4, 32'hB0, 2);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("abort_scyc", 64'(s_cyc_o), 64'd0);
    check("abort_grant", 64'(grant_o), 64'd0);
    check("abort_ack", 64'(m_ack_o), 64'd0);
    wb_rst_i = 1'b0; tcyc[3] = 1'b0; tstb[3] = 1'b0;
    @(posedge wb_clk_i); #1;
    run_id++; tight = 1;
    gq.push_back(0); gq.push_back(3);
    push_beats(0, 1, 26'h500, 1, 32'hD0);
    push_beats(3, 1, 26'h504, 1, 32'hD3);
    fork
      wb_burst(0, 1, 26'h500, 1, 32'hD0, 0);
      wb_burst(3, 1, 26'h504, 1, 32'hD3, 0);
    join
    repeat (3) @(posedge wb_clk_i); #1;

    // Master 0 releases while master 1 waits; then master 1 reads master 0's word.
    run_id++; tight = 1;
    gq.push_back(0); gq.push_back(1);
    push_beats(0, 1, 26'h600, 1, 32'hE0);
    push_beats(1, 1, 26'h604, 1, 32'hE1);
    fork
      wb_burst(0, 1, 26'h600, 1, 32'hE0, 0);
      wb_burst(1, 1, 26'h604, 1, 32'hE1, 0);
    join
    @(posedge wb_clk_i); #1;
    run_id++; tight = 0;
    gq.push_back(1);
    push_beats(1, 0, 26'h600, 1, 32'hE0);
    wb_burst(1, 0, 26'h600, 1, 32'hE0, 0);

    repeat (5) @(negedge wb_clk_i);
    check("grant_q_left", 64'(gq.size()), 64'd0);
    check("beat_q_left", 64'(sq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
